// File: rtl/seq_mac_pkg.sv
// seq_mac_pkg: shared types, mode encodings and helpers for the seq_mac_unit slice.
package seq_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_MUL = 2'b00;
    localparam logic [1:0] MODE_MAC = 2'b01;
    localparam logic [1:0] MODE_CLR = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    // Ceiling log2; clog2(WIDTH+1) sizes a counter that can hold WIDTH itself.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/seq_mac_unit_if.sv
// seq_mac_unit_if: request/response bundle of the sequential MAC unit.
// signed_op exists only when SEQ_MAC_SIGNED_EN is defined.
interface seq_mac_unit_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2*WIDTH+4
);
    logic             ena;
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SEQ_MAC_SIGNED_EN
    logic             signed_op;
`endif
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] result;
    logic             overflow;

`ifdef SEQ_MAC_SIGNED_EN
    modport master (
        output ena, start, mode, a, b, signed_op,
        input  busy, done, result, overflow
    );

    modport slave (
        input  ena, start, mode, a, b, signed_op,
        output busy, done, result, overflow
    );
`else
    modport master (
        output ena, start, mode, a, b,
        input  busy, done, result, overflow
    );

    modport slave (
        input  ena, start, mode, a, b,
        output busy, done, result, overflow
    );
`endif

endinterface

// File: rtl/seq_mac_core.sv
// seq_mac_core: shift-add datapath retiring one multiplier bit per step.
// Signed operands are multiplied as magnitudes and the product negated at the end.
module seq_mac_core
    import seq_mac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               signed_o,
    output logic               last_o
);
    localparam int PW    = 2*WIDTH;
    localparam int CNT_W = clog2(WIDTH+1);

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    pp_q, pp_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic             neg_q, neg_d;
    logic             signed_q, signed_d;

    logic [WIDTH-1:0] magA, magB;
    logic [PW-1:0]    ppSum;

    // Two's complement of the most negative value still fits as an unsigned magnitude.
    always_comb begin
        magA = a_i;
        magB = b_i;
        if (signed_i && a_i[WIDTH-1]) begin
            magA = (~a_i) + WIDTH'(1);
        end
        if (signed_i && b_i[WIDTH-1]) begin
            magB = (~b_i) + WIDTH'(1);
        end
    end

    always_comb begin
        ppSum     = pp_q + (mplier_q[0] ? mcand_q : '0);
        product_o = neg_q ? ((~ppSum) + PW'(1)) : ppSum;
        signed_o  = signed_q;
        last_o    = (bitCnt_q == CNT_W'(WIDTH-1));
    end

    always_comb begin
        mcand_d  = mcand_q;
        pp_d     = pp_q;
        mplier_d = mplier_q;
        bitCnt_d = bitCnt_q;
        neg_d    = neg_q;
        signed_d = signed_q;
        if (load_i) begin
            mcand_d  = {{WIDTH{1'b0}}, magA};
            pp_d     = '0;
            mplier_d = magB;
            bitCnt_d = '0;
            neg_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            signed_d = signed_i;
        end else if (step_i) begin
            mcand_d  = mcand_q << 1;
            pp_d     = ppSum;
            mplier_d = mplier_q >> 1;
            bitCnt_d = bitCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            pp_q     <= '0;
            mplier_q <= '0;
            bitCnt_q <= '0;
            neg_q    <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            pp_q     <= pp_d;
            mplier_q <= mplier_d;
            bitCnt_q <= bitCnt_d;
            neg_q    <= neg_d;
            signed_q <= signed_d;
        end
    end

endmodule

// File: rtl/seq_mac_unit.sv
// seq_mac_unit: iterative multiplier / multiply-accumulate with start/done handshake.
// Define SEQ_MAC_SIGNED_EN to add the signed_op input and two's complement arithmetic.
module seq_mac_unit
    import seq_mac_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2*WIDTH+4
) (
    input logic          clk,
    input logic          rst_n,
    seq_mac_unit_if.slave macIf
);
    localparam int PW = 2*WIDTH;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;

    logic             startAccept;
    logic             loadOp;
    logic             clearOp;
    logic             stepOp;
    logic             finishOp;

    logic             opSigned;
    logic             coreSigned;
    logic             coreLast;
    logic [PW-1:0]    coreProduct;
    logic [ACC_W-1:0] extProduct;
    logic [ACC_W:0]   macSum;
    logic             macOverflow;

`ifdef SEQ_MAC_SIGNED_EN
    assign opSigned = macIf.signed_op;
`else
    assign opSigned = 1'b0;
`endif

    seq_mac_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (loadOp),
        .step_i    (stepOp),
        .a_i       (macIf.a),
        .b_i       (macIf.b),
        .signed_i  (opSigned),
        .product_o (coreProduct),
        .signed_o  (coreSigned),
        .last_o    (coreLast)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A clear finishes in the accepting cycle, so it jumps straight to DONE.
    always_comb begin
        state_d = state_q;
        if (macIf.ena) begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (startAccept) begin
                        state_d = (macIf.mode == MODE_CLR) ? DONE : RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (coreLast) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        startAccept = 1'b0;
        loadOp      = 1'b0;
        clearOp     = 1'b0;
        stepOp      = 1'b0;
        finishOp    = 1'b0;
        if (macIf.ena) begin
            unique case (state_q)
                IDLE, DONE: begin
                    startAccept = macIf.start;
                    clearOp     = macIf.start && (macIf.mode == MODE_CLR);
                    loadOp      = macIf.start && (macIf.mode != MODE_CLR);
                end
                RUN: begin
                    stepOp   = 1'b1;
                    finishOp = coreLast;
                end
                default: begin
                    startAccept = 1'b0;
                end
            endcase
        end
    end

    // done is withheld while ena is low so the pulse is seen exactly once.
    assign macIf.busy     = (state_q == RUN);
    assign macIf.done     = (state_q == DONE) && macIf.ena;
    assign macIf.result   = result_q;
    assign macIf.overflow = overflow_q;

    always_comb begin
        mode_d = loadOp ? macIf.mode : mode_q;
    end

    always_comb begin
        extProduct = coreSigned ? ACC_W'($signed(coreProduct)) : ACC_W'(coreProduct);
        macSum     = {1'b0, result_q} + {1'b0, extProduct};
        if (coreSigned) begin
            macOverflow = (result_q[ACC_W-1] == extProduct[ACC_W-1]) &&
                          (macSum[ACC_W-1] != result_q[ACC_W-1]);
        end else begin
            macOverflow = macSum[ACC_W];
        end

        result_d   = result_q;
        overflow_d = overflow_q;
        if (clearOp) begin
            result_d   = '0;
            overflow_d = 1'b0;
        end else if (finishOp) begin
            if (mode_q == MODE_MAC) begin
                result_d   = macSum[ACC_W-1:0];
                overflow_d = overflow_q | macOverflow;
            end else begin
                result_d   = extProduct;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_MUL;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_seq_mac_unit.sv
// tb_seq_mac_unit: directed scoreboard bench for seq_mac_unit (WIDTH=8, ACC_W=20).
// Signed vectors are exercised only when SEQ_MAC_SIGNED_EN is defined.
module tb_seq_mac_unit;
    import seq_mac_pkg::*;

    localparam int W   = 8;
    localparam int ACC = 2*W+4;

    typedef struct {
        logic [ACC-1:0] res;
        logic           ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    seq_mac_unit_if #(.WIDTH(W), .ACC_W(ACC)) bus ();

    seq_mac_unit #(.WIDTH(W), .ACC_W(ACC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .macIf (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [ACC-1:0] res, input logic ovf);
        exp_t e;
        e.res = res;
        e.ovf = ovf;
        expQ.push_back(e);
    endtask

    // One operation: start pulse, optional stray start mid-RUN, optional 3-cycle ena gap.
    task automatic applyStimulus(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [ACC-1:0] expRes, input logic expOvf,
                                 input int expLat, input int intrudeAt, input int gapAt);
        int  cyc;
        bit  seen;
        pushExp(expRes, expOvf);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                checkOutput("busy_while_running", bus.busy, 1);
            end
            if (intrudeAt != 0 && cyc == intrudeAt) begin
                bus.start = 1'b1;
                bus.mode  = MODE_MAC;
                bus.a     = 8'd1;
                bus.b     = 8'd1;
            end else if (intrudeAt != 0 && cyc == intrudeAt + 1) begin
                bus.start = 1'b0;
                bus.mode  = m;
            end
            if (gapAt != 0 && cyc == gapAt) begin
                bus.ena = 1'b0;
            end else if (gapAt != 0 && cyc == gapAt + 3) begin
                bus.ena = 1'b1;
            end
        end
        checkOutput("latency", cyc, expLat);
    endtask

    // Scoreboard monitor: every visible done pulse consumes one expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got result %0d with no expected entry", bus.result);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("result", 32'(bus.result), 32'(e.res));
                    checkOutput("overflow", 32'(bus.overflow), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        int cyc;
        int lastDone;

        bus.ena   = 1'b1;
        bus.start = 1'b0;
        bus.mode  = MODE_MUL;
        bus.a     = '0;
        bus.b     = '0;
`ifdef SEQ_MAC_SIGNED_EN
        bus.signed_op = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 0);
        checkOutput("reset_done", 32'(bus.done), 0);
        checkOutput("reset_result", 32'(bus.result), 0);
        checkOutput("reset_overflow", 32'(bus.overflow), 0);
        rst_n = 1'b1;

        applyStimulus(MODE_MUL, 8'd15, 8'd10, 20'd150, 1'b0, 9, 0, 0);
        applyStimulus(MODE_MUL, 8'd255, 8'd255, 20'd65025, 1'b0, 9, 0, 0);
        applyStimulus(MODE_MAC, 8'd3, 8'd4, 20'd65037, 1'b0, 9, 0, 0);
        applyStimulus(MODE_CLR, 8'd0, 8'd0, 20'd0, 1'b0, 1, 0, 0);

        for (int n = 1; n <= 17; n++) begin
            if (n < 17) begin
                applyStimulus(MODE_MAC, 8'd255, 8'd255, ACC'(65025 * n), 1'b0, 9, 0, 0);
            end else begin
                applyStimulus(MODE_MAC, 8'd255, 8'd255, 20'd56849, 1'b1, 9, 0, 0);
            end
        end

        applyStimulus(MODE_MUL, 8'd2, 8'd3, 20'd6, 1'b1, 9, 0, 0);
        applyStimulus(MODE_RSV, 8'd7, 8'd9, 20'd63, 1'b1, 9, 0, 0);
        applyStimulus(MODE_MUL, 8'd15, 8'd10, 20'd150, 1'b1, 9, 3, 0);
        applyStimulus(MODE_MUL, 8'd12, 8'd12, 20'd144, 1'b1, 12, 0, 4);
        applyStimulus(MODE_CLR, 8'd0, 8'd0, 20'd0, 1'b0, 1, 0, 0);

        // start held high: three back-to-back operations, one done every 9 cycles
        repeat (3) pushExp(20'd10, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = MODE_MUL;
        bus.a     = 8'd2;
        bus.b     = 8'd5;
        cnt      = 0;
        cyc      = 0;
        lastDone = 0;
        @(posedge clk);
        while (cnt < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                cnt++;
                if (cnt == 1) begin
                    checkOutput("held_first_latency", cyc, 9);
                end else begin
                    checkOutput("held_done_spacing", cyc - lastDone, 9);
                end
                lastDone = cyc;
                if (cnt == 3) begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        checkOutput("held_done_count", cnt, 3);

        // reset in RUN cycle 4 discards the operation; no done may follow
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = MODE_MUL;
        bus.a     = 8'd15;
        bus.b     = 8'd10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("pre_reset_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrun_reset_busy", 32'(bus.busy), 0);
        checkOutput("midrun_reset_done", 32'(bus.done), 0);
        checkOutput("midrun_reset_result", 32'(bus.result), 0);
        checkOutput("midrun_reset_overflow", 32'(bus.overflow), 0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);

`ifdef SEQ_MAC_SIGNED_EN
        bus.signed_op = 1'b1;
        applyStimulus(MODE_MUL, 8'hFD, 8'd5, 20'hFFFF1, 1'b0, 9, 0, 0);
        applyStimulus(MODE_MUL, 8'h80, 8'h80, 20'd16384, 1'b0, 9, 0, 0);
        applyStimulus(MODE_MAC, 8'hFD, 8'd5, 20'd16369, 1'b0, 9, 0, 0);
        bus.signed_op = 1'b0;
`endif
        applyStimulus(MODE_MUL, 8'hFD, 8'd5, 20'd1265, 1'b0, 9, 0, 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
